// File: rtl/map_access_arbiter_pkg.sv
// map_access_arbiter_pkg: shared tile-map geometry, client FSM states and the xy address map.
package map_access_arbiter_pkg;
  localparam int COLS = 40;
  localparam int ROWS = 30;
  localparam int AW = 11;
  typedef enum logic [2:0] {C_IDLE, C_PEND, C_ISSUE, C_DATA, C_HOLD} client_state_t;
  function automatic logic [AW-1:0] xy_to_addr(input logic [5:0] x, input logic [5:0] y);
    return ({5'd0, y} << 5) + ({5'd0, y} << 3) + {5'd0, x};
  endfunction
  function automatic logic in_range(input logic [5:0] x, input logic [5:0] y);
    return x < 6'(COLS) && y < 6'(ROWS);
  endfunction
endpackage

// File: rtl/map_access_arbiter_client.sv
// map_client_port: one client's get/update handshake FSM with its starvation counter.
module map_client_port
  import map_access_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 64
) (
  input  logic          px_clk,
  input  logic          rst,
  input  logic          get,
  input  logic          update,
  input  logic [5:0]    posx,
  input  logic [5:0]    posy,
  input  logic [7:0]    wdata,
  input  logic          grant,
  input  logic [7:0]    ram_rdata,
  output logic          pend,
  output logic          starved,
  output logic          wr,
  output logic          inrange,
  output logic [AW-1:0] addr,
  output logic [7:0]    req_wdata,
  output logic [7:0]    rdata,
  output logic          ready
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  client_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic hold_seen;
  always_ff @(posedge px_clk) begin
    if (rst) begin
      state <= C_IDLE;
      cnt <= '0;
      hold_seen <= 1'b0;
      wr <= 1'b0;
      inrange <= 1'b0;
      addr <= '0;
      req_wdata <= '0;
      rdata <= '0;
    end else begin
      state <= state_n;
      cnt <= (state != C_PEND || grant) ? '0 : cnt + CW'(!starved);
      hold_seen <= state == C_HOLD;
      if (state == C_IDLE && (get || update)) begin
        wr <= update;
        inrange <= in_range(posx, posy);
        addr <= xy_to_addr(posx, posy);
        req_wdata <= wdata;
      end
      if (state == C_DATA) rdata <= inrange ? ram_rdata : 8'd0;
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      C_IDLE:  state_n = (get || update) ? C_PEND : C_IDLE;
      C_PEND:  state_n = grant ? (wr ? C_HOLD : C_ISSUE) : C_PEND;
      C_ISSUE: state_n = C_DATA;
      C_DATA:  state_n = C_HOLD;
      C_HOLD:  state_n = (get || update) ? C_HOLD : C_IDLE;
      default: state_n = C_IDLE;
    endcase
  end
  always_comb begin
    pend = state == C_PEND;
    starved = pend && cnt == CW'(STARVE_LIMIT);
    ready = state == C_HOLD && !hold_seen;
  end
endmodule

// File: rtl/map_access_arbiter.sv
// map_access_arbiter: single-port tile-map RAM shared by display fetch and two client ports.
module map_access_arbiter
  import map_access_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 64
) (
  input  logic          px_clk,
  input  logic          rst,
  input  logic          disp_req,
  input  logic [5:0]    disp_x,
  input  logic [5:0]    disp_y,
  output logic [7:0]    disp_data,
  output logic          disp_valid,
  output logic          disp_miss,
  input  logic          a_get,
  input  logic          a_update,
  input  logic [5:0]    a_posx,
  input  logic [5:0]    a_posy,
  input  logic [7:0]    a_wdata,
  output logic [7:0]    a_rdata,
  output logic          a_ready,
  input  logic          b_get,
  input  logic [5:0]    b_posx,
  input  logic [5:0]    b_posy,
  output logic [7:0]    b_rdata,
  output logic          b_ready,
  output logic          busy,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_wdata,
  input  logic [7:0]    ram_rdata
);
  logic disp_req_q, dq_in, v1, v2, in1, in2, m1, m2, rr;
  logic [AW-1:0] dq_addr, a_addr, b_addr, sel_addr;
  logic a_pend, b_pend, a_starved, b_starved, a_wr, b_wr, a_in, b_in;
  logic ga, gb, steal, g_any, sel_wr, sel_in;
  logic [7:0] a_wd, b_wd, sel_wd;
  map_client_port #(.STARVE_LIMIT(STARVE_LIMIT)) u_a (
    .px_clk(px_clk), .rst(rst), .get(a_get), .update(a_update), .posx(a_posx), .posy(a_posy),
    .wdata(a_wdata), .grant(ga), .ram_rdata(ram_rdata), .pend(a_pend), .starved(a_starved),
    .wr(a_wr), .inrange(a_in), .addr(a_addr), .req_wdata(a_wd), .rdata(a_rdata), .ready(a_ready)
  );
  map_client_port #(.STARVE_LIMIT(STARVE_LIMIT)) u_b (
    .px_clk(px_clk), .rst(rst), .get(b_get), .update(1'b0), .posx(b_posx), .posy(b_posy),
    .wdata(8'd0), .grant(gb), .ram_rdata(ram_rdata), .pend(b_pend), .starved(b_starved),
    .wr(b_wr), .inrange(b_in), .addr(b_addr), .req_wdata(b_wd), .rdata(b_rdata), .ready(b_ready)
  );
  // rr=0 favours A on a tie; a starved client outranks display for one slot
  always_comb begin
    steal = a_starved | b_starved;
    ga = steal ? a_starved & (!b_starved | !rr) : !disp_req_q & a_pend & (!b_pend | !rr);
    gb = steal ? b_starved & (!a_starved | rr) : !disp_req_q & b_pend & (!a_pend | rr);
    g_any = ga | gb;
    sel_addr = ga ? a_addr : b_addr;
    sel_wr = ga ? a_wr : b_wr;
    sel_in = ga ? a_in : b_in;
    sel_wd = ga ? a_wd : b_wd;
    busy = !steal & disp_req_q;
  end
  always_ff @(posedge px_clk) begin
    if (rst) begin
      disp_req_q <= 1'b0;
      dq_in <= 1'b0;
      dq_addr <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      in1 <= 1'b0;
      in2 <= 1'b0;
      m1 <= 1'b0;
      m2 <= 1'b0;
      rr <= 1'b0;
      ram_addr <= '0;
      ram_we <= 1'b0;
      ram_wdata <= '0;
    end else begin
      disp_req_q <= disp_req;
      dq_in <= in_range(disp_x, disp_y);
      dq_addr <= xy_to_addr(disp_x, disp_y);
      v1 <= busy;
      in1 <= dq_in;
      m1 <= steal & disp_req_q;
      v2 <= v1;
      in2 <= in1;
      m2 <= m1;
      ram_we <= g_any & sel_wr & sel_in;
      if (busy & dq_in) ram_addr <= dq_addr;
      else if (g_any & sel_in) ram_addr <= sel_addr;
      if (g_any & sel_wr & sel_in) ram_wdata <= sel_wd;
      if (g_any) rr <= ga;
    end
  end
  assign disp_valid = v2;
  assign disp_miss = m2;
  assign disp_data = (v2 & in2) ? ram_rdata : 8'd0;
endmodule
